// File: rtl/mont_exp_ctrl_pkg.sv
// Shared definitions for the Montgomery exponentiation controller:
// default widths, FSM state encoding and the multiplier operation type.
package mont_exp_ctrl_pkg;

    localparam int DEF_WIDTH     = 381;
    localparam int DEF_EXP_WIDTH = 381;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_SETUP = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_ACK   = 3'd5,
        ST_NEXT  = 3'd6,
        ST_FIN   = 3'd7
    } state_e;

    typedef enum logic {
        OP_SQR = 1'b0,
        OP_MUL = 1'b1
    } op_e;

endpackage

// File: rtl/mont_exp_ctrl_if.sv
// Bus between the exponentiation controller, its host and the external
// Montgomery multiplier. slave = controller view, master = host/multiplier view.
interface mont_exp_ctrl_if
    import mont_exp_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int EXP_WIDTH = DEF_EXP_WIDTH
);
    // host request / response
    logic                 start;
    logic [WIDTH-1:0]     x_mont;
    logic [WIDTH-1:0]     one_mont;
    logic [EXP_WIDTH-1:0] exp;
    logic [WIDTH-1:0]     modulus;
    logic                 out_read;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     result;
    // multiplier side
    logic                 mm_start;
    logic [WIDTH-1:0]     mm_a;
    logic [WIDTH-1:0]     mm_b;
    logic [WIDTH-1:0]     mm_m;
    logic                 mm_out_read;
    logic [WIDTH-1:0]     mm_result;
    logic                 mm_done;

    modport slave (
        input  start, x_mont, one_mont, exp, modulus, out_read,
        input  mm_result, mm_done,
        output busy, done, result,
        output mm_start, mm_a, mm_b, mm_m, mm_out_read
    );

    modport master (
        output start, x_mont, one_mont, exp, modulus, out_read,
        output mm_result, mm_done,
        input  busy, done, result,
        input  mm_start, mm_a, mm_b, mm_m, mm_out_read
    );

endinterface

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply controller driving an external
// Montgomery multiplier. Leading exponent zeros are skipped, the first
// set bit loads acc = x, and each remaining bit costs one square plus a
// multiply when the bit is set.
module mont_exp_ctrl
    import mont_exp_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int EXP_WIDTH = DEF_EXP_WIDTH
) (
    input  logic           clk,
    input  logic           resetn,
    mont_exp_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(EXP_WIDTH + 1);

    state_e               r_state;
    state_e               w_next;
    op_e                  r_op;
    logic [EXP_WIDTH-1:0] r_exp;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_x;
    logic [WIDTH-1:0]     r_m;
    logic [WIDTH-1:0]     r_mm_a;
    logic [WIDTH-1:0]     r_mm_b;
    logic [WIDTH-1:0]     r_mm_m;
    logic [WIDTH-1:0]     r_result;
    logic                 r_setup_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_mm_start;
    logic                 r_mm_out_read;

    logic                 w_msb;
    logic [CNT_W-1:0]     w_cnt_dec;

    // r_exp is shifted so its MSB is always the bit being processed
    assign w_msb     = r_exp[EXP_WIDTH-1];
    assign w_cnt_dec = r_cnt - CNT_W'(1);

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_next = ST_SCAN;
            // r_cnt holds the bits still unexamined, including the MSB
            ST_SCAN: begin
                if (w_msb)                    w_next = ST_NEXT;
                else if (r_cnt <= CNT_W'(1))  w_next = ST_FIN;
            end
            ST_SETUP: if (r_setup_cnt) w_next = ST_ISSUE;
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT:  if (bus.mm_done) w_next = ST_ACK;
            ST_ACK:   w_next = (r_op == OP_SQR && w_msb) ? ST_SETUP : ST_NEXT;
            ST_NEXT:  w_next = (w_cnt_dec != '0) ? ST_SETUP : ST_FIN;
            ST_FIN:   if (bus.out_read) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // datapath and registered outputs; outputs follow the state being entered
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op          <= OP_SQR;
            r_exp         <= '0;
            r_cnt         <= '0;
            r_acc         <= '0;
            r_x           <= '0;
            r_m           <= '0;
            r_mm_a        <= '0;
            r_mm_b        <= '0;
            r_mm_m        <= '0;
            r_result      <= '0;
            r_setup_cnt   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_mm_start    <= 1'b0;
            r_mm_out_read <= 1'b0;
        end else begin
            r_busy        <= !(w_next == ST_IDLE || w_next == ST_FIN);
            r_done        <= (w_next == ST_FIN);
            r_mm_start    <= (w_next == ST_ISSUE);
            r_mm_out_read <= (w_next == ST_ACK);
            // two-cycle operand settle window inside SETUP
            r_setup_cnt   <= (r_state == ST_SETUP) ? ~r_setup_cnt : 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_x   <= bus.x_mont;
                        r_m   <= bus.modulus;
                        r_exp <= bus.exp;
                        r_acc <= bus.one_mont;
                        r_cnt <= CNT_W'(EXP_WIDTH);
                    end
                end
                ST_SCAN: begin
                    if (w_msb) begin
                        r_acc <= r_x;
                        r_op  <= OP_SQR;
                    end else if (r_cnt > CNT_W'(1)) begin
                        r_exp <= r_exp << 1;
                        r_cnt <= w_cnt_dec;
                    end
                end
                ST_WAIT: begin
                    if (bus.mm_done) r_acc <= bus.mm_result;
                end
                ST_ACK: begin
                    // operands load on entry to SETUP so they sit stable for both cycles
                    if (r_op == OP_SQR && w_msb) begin
                        r_op   <= OP_MUL;
                        r_mm_a <= r_acc;
                        r_mm_b <= r_x;
                        r_mm_m <= r_m;
                    end
                end
                ST_NEXT: begin
                    r_cnt <= w_cnt_dec;
                    if (w_cnt_dec != '0) begin
                        r_exp  <= r_exp << 1;
                        r_op   <= OP_SQR;
                        r_mm_a <= r_acc;
                        r_mm_b <= r_acc;
                        r_mm_m <= r_m;
                    end
                end
                default: ;
            endcase

            if (w_next == ST_FIN && r_state != ST_FIN) r_result <= r_acc;
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.result      = r_result;
    assign bus.mm_start    = r_mm_start;
    assign bus.mm_a        = r_mm_a;
    assign bus.mm_b        = r_mm_b;
    assign bus.mm_m        = r_mm_m;
    assign bus.mm_out_read = r_mm_out_read;

endmodule
